// File: rtl/wb_bus_master_if.sv
// Bus bundle for wb_bus_master: pipeline memory-port signals on one side,
// classic Wishbone master signals on the other.
// The master modport is the view taken by wb_bus_master.
// The slave modport is the view of whatever drives the pipeline side and
// responds on the bus, such as a test environment.
interface wb_bus_master_if;
   logic        cpu_ce_i;
   logic        cpu_we_i;
   logic [31:0] cpu_addr_i;
   logic [15:0] cpu_select_i;
   logic [3:0]  cpu_sel_i;
   logic [31:0] cpu_data_i;
   logic        cpu_tlb_exc_i;
   logic        stall_i;
   logic        flush_i;
   logic [31:0] cpu_data_o;
   logic        stallreq_o;
   logic        bus_err_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic        wb_we_o;
   logic [3:0]  wb_sel_o;
   logic        wb_stb_o;
   logic        wb_cyc_o;
   logic [15:0] wb_slave_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;

   modport master (
      input  cpu_ce_i, cpu_we_i, cpu_addr_i, cpu_select_i, cpu_sel_i,
             cpu_data_i, cpu_tlb_exc_i, stall_i, flush_i, wb_dat_i, wb_ack_i,
      output cpu_data_o, stallreq_o, bus_err_o, wb_adr_o, wb_dat_o, wb_we_o,
             wb_sel_o, wb_stb_o, wb_cyc_o, wb_slave_o
   );

   modport slave (
      output cpu_ce_i, cpu_we_i, cpu_addr_i, cpu_select_i, cpu_sel_i,
             cpu_data_i, cpu_tlb_exc_i, stall_i, flush_i, wb_dat_i, wb_ack_i,
      input  cpu_data_o, stallreq_o, bus_err_o, wb_adr_o, wb_dat_o, wb_we_o,
             wb_sel_o, wb_stb_o, wb_cyc_o, wb_slave_o
   );
endinterface

// File: rtl/wb_bus_master.sv
// wb_bus_master: single-cycle classic Wishbone master for the IF/MEM ports.
// Runs one bus cycle at a time and stalls the pipeline until it completes.
// Handles flush, held pipeline stalls (HOLD), unmapped slaves and
// translation exceptions.
//
// Optional feature:
//   WB_TIMEOUT_EN  When defined, an ack timeout counter aborts a BUSY cycle
//                  after TIMEOUT_CYCLES cycles and pulses bus_err_o.
//                  When undefined, BUSY waits indefinitely and bus_err_o is 0.
module wb_bus_master #(
   parameter int TO_WIDTH       = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic            clk,
   input logic            rst,
   wb_bus_master_if.master bus
);

   typedef enum logic [1:0] {IDLE, BUSY, HOLD} busState_e;

   busState_e   r_state;
   busState_e   w_nextState;

   logic [31:0] r_wbAdr;
   logic [31:0] r_wbDat;
   logic        r_wbWe;
   logic [3:0]  r_wbSel;
   logic        r_wbStb;
   logic        r_wbCyc;
   logic [15:0] r_wbSlave;
   logic [31:0] r_rdBuf;

   logic        w_start;
   logic        w_timeout;
   logic        w_stallReq;
   logic [31:0] w_cpuData;
   logic        w_busErr;

   // A request may open a bus cycle only if it is mapped, not flushed and
   // did not fault in translation.
   assign w_start = bus.cpu_ce_i && !bus.flush_i && !bus.cpu_tlb_exc_i &&
                    (bus.cpu_select_i != 16'h0000);

`ifdef WB_TIMEOUT_EN
   logic [TO_WIDTH-1:0] r_toCnt;

   // Count BUSY cycles without ack; cleared whenever a new cycle is opened.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_toCnt <= '0;
      end else if (r_state == IDLE && w_start) begin
         r_toCnt <= '0;
      end else if (r_state == BUSY && !bus.wb_ack_i) begin
         r_toCnt <= r_toCnt + TO_WIDTH'(1);
      end
   end

   // The last permitted BUSY cycle is the one where the count equals
   // TIMEOUT_CYCLES-1, so the abort lands after exactly TIMEOUT_CYCLES cycles.
   assign w_timeout = (r_state == BUSY) && !bus.wb_ack_i && !bus.flush_i &&
                      (r_toCnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));
`else
   logic w_unusedCfg;

   assign w_unusedCfg = (TO_WIDTH == TIMEOUT_CYCLES);
   assign w_timeout   = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic; flush always wins over ack in BUSY and HOLD.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_nextState = BUSY;
            end
         end
         BUSY: begin
            if (bus.flush_i) begin
               w_nextState = IDLE;
            end else if (bus.wb_ack_i) begin
               w_nextState = bus.stall_i ? HOLD : IDLE;
            end else if (w_timeout) begin
               w_nextState = IDLE;
            end
         end
         HOLD: begin
            if (!bus.stall_i || bus.flush_i) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Pipeline-facing outputs; read data passes through combinationally in
   // the ack cycle and is replayed from rd_buf while HOLD lasts.
   always_comb begin
      w_stallReq = 1'b0;
      w_cpuData  = '0;
      w_busErr   = 1'b0;
      if (!rst) begin
         case (r_state)
            IDLE: w_stallReq = w_start;
            BUSY: begin
               if (!bus.flush_i) begin
                  if (bus.wb_ack_i) begin
                     w_cpuData = bus.wb_dat_i;
                  end else if (w_timeout) begin
                     w_busErr = 1'b1;
                  end else begin
                     w_stallReq = 1'b1;
                  end
               end
            end
            HOLD:    w_cpuData = r_rdBuf;
            default: w_cpuData = '0;
         endcase
      end
   end

   // Wishbone request registers and read buffer; slave select is cleared
   // together with cyc so it is never seen outside a cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wbAdr   <= '0;
         r_wbDat   <= '0;
         r_wbWe    <= 1'b0;
         r_wbSel   <= '0;
         r_wbStb   <= 1'b0;
         r_wbCyc   <= 1'b0;
         r_wbSlave <= '0;
         r_rdBuf   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_wbAdr   <= bus.cpu_addr_i;
                  r_wbDat   <= bus.cpu_data_i;
                  r_wbWe    <= bus.cpu_we_i;
                  r_wbSel   <= bus.cpu_sel_i;
                  r_wbSlave <= bus.cpu_select_i;
                  r_wbStb   <= 1'b1;
                  r_wbCyc   <= 1'b1;
               end
            end
            BUSY: begin
               if (bus.flush_i || bus.wb_ack_i || w_timeout) begin
                  r_wbStb   <= 1'b0;
                  r_wbCyc   <= 1'b0;
                  r_wbSlave <= '0;
                  if (bus.wb_ack_i && !bus.flush_i) begin
                     r_rdBuf <= bus.wb_dat_i;
                  end
               end
            end
            default: begin
               r_wbStb <= r_wbStb;
            end
         endcase
      end
   end

   assign bus.wb_adr_o   = r_wbAdr;
   assign bus.wb_dat_o   = r_wbDat;
   assign bus.wb_we_o    = r_wbWe;
   assign bus.wb_sel_o   = r_wbSel;
   assign bus.wb_stb_o   = r_wbStb;
   assign bus.wb_cyc_o   = r_wbCyc;
   assign bus.wb_slave_o = r_wbSlave;
   assign bus.cpu_data_o = w_cpuData;
   assign bus.stallreq_o = w_stallReq;
   assign bus.bus_err_o  = w_busErr;

endmodule

// File: tb/tb_wb_bus_master.sv
// Directed testbench for wb_bus_master: read, back-to-back write, HOLD,
// flush, unmapped/exception requests, reset mid-cycle and, with
// WB_TIMEOUT_EN, the ack timeout.
module tb_wb_bus_master;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   stallCnt;
   int   cycCnt;

   always #5 clk = ~clk;

   wb_bus_master_if busIf ();

   wb_bus_master #(.TO_WIDTH(8), .TIMEOUT_CYCLES(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (busIf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic ce, input logic we,
                                input logic [31:0] addr, input logic [15:0] slv,
                                input logic [3:0] sel, input logic [31:0] data,
                                input logic tlb, input logic stall,
                                input logic flush, input logic ack,
                                input logic [31:0] datIn);
      busIf.cpu_ce_i      = ce;
      busIf.cpu_we_i      = we;
      busIf.cpu_addr_i    = addr;
      busIf.cpu_select_i  = slv;
      busIf.cpu_sel_i     = sel;
      busIf.cpu_data_i    = data;
      busIf.cpu_tlb_exc_i = tlb;
      busIf.stall_i       = stall;
      busIf.flush_i       = flush;
      busIf.wb_ack_i      = ack;
      busIf.wb_dat_i      = datIn;
      #1;
   endtask

   task automatic idleInputs();
      applyStimulus(1'b0, 1'b0, 32'h0, 16'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic checkBit(input string tag, input logic observed, input logic expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   initial begin
      // Reset, with a request already presented: no stall may leak out.
      rst = 1'b1;
      applyStimulus(1'b1, 1'b0, 32'h1000, 16'h0001, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checkBit("rst_stallreq", busIf.stallreq_o, 1'b0);
      tick();
      tick();
      checkBit("rst_cyc", busIf.wb_cyc_o, 1'b0);
      checkBit("rst_stb", busIf.wb_stb_o, 1'b0);
      checkOutput("rst_adr", busIf.wb_adr_o, 32'h0);
      checkOutput("rst_slave", 32'(busIf.wb_slave_o), 32'h0);
      checkOutput("rst_cpu_data", busIf.cpu_data_o, 32'h0);
      checkBit("rst_bus_err", busIf.bus_err_o, 1'b0);
      idleInputs();
      rst = 1'b0;
      tick();

      // Read from RAM, ack after three wait cycles.
      $display("[TB] read with wait states");
      applyStimulus(1'b1, 1'b0, 32'h0000_1000, 16'h0001, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      stallCnt = 0;
      checkBit("rd_req_stallreq", busIf.stallreq_o, 1'b1);
      checkBit("rd_req_cyc", busIf.wb_cyc_o, 1'b0);
      stallCnt += int'(busIf.stallreq_o);
      tick();
      checkBit("rd_busy_cyc", busIf.wb_cyc_o, 1'b1);
      checkBit("rd_busy_stb", busIf.wb_stb_o, 1'b1);
      checkOutput("rd_busy_adr", busIf.wb_adr_o, 32'h0000_1000);
      checkBit("rd_busy_we", busIf.wb_we_o, 1'b0);
      checkOutput("rd_busy_sel", 32'(busIf.wb_sel_o), 32'hF);
      checkOutput("rd_busy_slave", 32'(busIf.wb_slave_o), 32'h1);
      checkBit("rd_busy_bus_err", busIf.bus_err_o, 1'b0);
      stallCnt += int'(busIf.stallreq_o);
      tick();
      stallCnt += int'(busIf.stallreq_o);
      tick();
      stallCnt += int'(busIf.stallreq_o);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0000_1000, 16'h0001, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      stallCnt += int'(busIf.stallreq_o);
      checkOutput("rd_ack_cpu_data", busIf.cpu_data_o, 32'hDEAD_BEEF);
      checkBit("rd_ack_stallreq", busIf.stallreq_o, 1'b0);
      checkOutput("rd_stall_cycles", 32'(stallCnt), 32'd4);
      tick();

      // Back-to-back write to the UART, ack in the first BUSY cycle.
      $display("[TB] back-to-back write");
      applyStimulus(1'b1, 1'b1, 32'h1FD0_03F8, 16'h0002, 4'b0001, 32'h41, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checkBit("wr_req_cyc", busIf.wb_cyc_o, 1'b0);
      checkBit("wr_req_stallreq", busIf.stallreq_o, 1'b1);
      checkOutput("wr_req_cpu_data", busIf.cpu_data_o, 32'h0);
      cycCnt = 0;
      tick();
      applyStimulus(1'b1, 1'b1, 32'h1FD0_03F8, 16'h0002, 4'b0001, 32'h41, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      cycCnt += int'(busIf.wb_cyc_o);
      checkBit("wr_we", busIf.wb_we_o, 1'b1);
      checkOutput("wr_dat", busIf.wb_dat_o, 32'h41);
      checkOutput("wr_sel", 32'(busIf.wb_sel_o), 32'h1);
      checkOutput("wr_adr", busIf.wb_adr_o, 32'h1FD0_03F8);
      checkOutput("wr_slave", 32'(busIf.wb_slave_o), 32'h2);
      checkBit("wr_ack_stallreq", busIf.stallreq_o, 1'b0);
      tick();
      idleInputs();
      cycCnt += int'(busIf.wb_cyc_o);
      checkOutput("wr_cyc_cycles", 32'(cycCnt), 32'd1);
      checkOutput("wr_idle_slave", 32'(busIf.wb_slave_o), 32'h0);

      // Ack while the pipeline is held: HOLD replays the latched data.
      $display("[TB] ack under held stall");
      applyStimulus(1'b1, 1'b0, 32'h0000_2000, 16'h0001, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0000_2000, 16'h0001, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D);
      checkOutput("hold_ack_cpu_data", busIf.cpu_data_o, 32'hCAFE_F00D);
      checkBit("hold_ack_stallreq", busIf.stallreq_o, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0000_2000, 16'h0001, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678);
      for (int i = 0; i < 3; i++) begin
         checkOutput("hold_cpu_data", busIf.cpu_data_o, 32'hCAFE_F00D);
         checkBit("hold_stallreq", busIf.stallreq_o, 1'b0);
         checkBit("hold_cyc", busIf.wb_cyc_o, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 16'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234_5678);
      checkOutput("hold_release_cpu_data", busIf.cpu_data_o, 32'hCAFE_F00D);
      tick();
      checkOutput("hold_idle_cpu_data", busIf.cpu_data_o, 32'h0);
      checkBit("hold_idle_cyc", busIf.wb_cyc_o, 1'b0);
      idleInputs();

      // Flush in BUSY, then a late ack that must be ignored.
      $display("[TB] flush during busy");
      applyStimulus(1'b1, 1'b0, 32'h0000_3000, 16'h0001, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0000_3000, 16'h0001, 4'hF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      checkBit("fl_stallreq", busIf.stallreq_o, 1'b0);
      checkOutput("fl_cpu_data", busIf.cpu_data_o, 32'h0);
      checkBit("fl_cyc_still", busIf.wb_cyc_o, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 16'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBADB_AD00);
      checkBit("fl_cyc_drop", busIf.wb_cyc_o, 1'b0);
      checkBit("fl_stb_drop", busIf.wb_stb_o, 1'b0);
      checkOutput("fl_slave_drop", 32'(busIf.wb_slave_o), 32'h0);
      checkOutput("fl_late_ack_cpu_data", busIf.cpu_data_o, 32'h0);
      checkBit("fl_late_ack_stallreq", busIf.stallreq_o, 1'b0);
      tick();
      idleInputs();
      checkBit("fl_after_cyc", busIf.wb_cyc_o, 1'b0);

      // Flush and ack in the same cycle with stall held: data discarded, no HOLD.
      applyStimulus(1'b1, 1'b0, 32'h0000_3004, 16'h0001, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0000_3004, 16'h0001, 4'hF, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h55AA_55AA);
      checkOutput("flack_cpu_data", busIf.cpu_data_o, 32'h0);
      checkBit("flack_stallreq", busIf.stallreq_o, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 16'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("flack_no_hold_cpu_data", busIf.cpu_data_o, 32'h0);
      checkBit("flack_cyc", busIf.wb_cyc_o, 1'b0);
      tick();
      idleInputs();

      // Translation exception, unmapped slave and flush in IDLE: no bus cycle.
      $display("[TB] exception and unmapped");
      applyStimulus(1'b1, 1'b0, 32'h0000_4000, 16'h0001, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkBit("tlb_stallreq", busIf.stallreq_o, 1'b0);
      checkOutput("tlb_cpu_data", busIf.cpu_data_o, 32'h0);
      tick();
      checkBit("tlb_cyc", busIf.wb_cyc_o, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0000_4000, 16'h0000, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checkBit("unmap_stallreq", busIf.stallreq_o, 1'b0);
      checkOutput("unmap_cpu_data", busIf.cpu_data_o, 32'h0);
      tick();
      checkBit("unmap_cyc", busIf.wb_cyc_o, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0000_4000, 16'h0001, 4'hF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      checkBit("idle_flush_stallreq", busIf.stallreq_o, 1'b0);
      tick();
      checkBit("idle_flush_cyc", busIf.wb_cyc_o, 1'b0);
      idleInputs();

      // Reset while BUSY abandons the transaction.
      $display("[TB] reset in busy");
      applyStimulus(1'b1, 1'b0, 32'h0000_5000, 16'h0004, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      checkBit("rstb_cyc_before", busIf.wb_cyc_o, 1'b1);
      rst = 1'b1;
      #1;
      checkBit("rstb_stallreq", busIf.stallreq_o, 1'b0);
      checkOutput("rstb_cpu_data", busIf.cpu_data_o, 32'h0);
      tick();
      checkBit("rstb_cyc", busIf.wb_cyc_o, 1'b0);
      checkBit("rstb_stb", busIf.wb_stb_o, 1'b0);
      checkOutput("rstb_adr", busIf.wb_adr_o, 32'h0);
      checkOutput("rstb_slave", 32'(busIf.wb_slave_o), 32'h0);
      rst = 1'b0;
      idleInputs();
      tick();
      checkBit("rstb_after_cyc", busIf.wb_cyc_o, 1'b0);
      checkBit("rstb_after_stallreq", busIf.stallreq_o, 1'b0);

`ifdef WB_TIMEOUT_EN
      // No ack: abort after eight BUSY cycles with a one-cycle bus_err_o.
      $display("[TB] ack timeout");
      applyStimulus(1'b1, 1'b0, 32'h0000_6000, 16'h0001, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      for (int i = 0; i < 7; i++) begin
         checkBit("to_wait_stallreq", busIf.stallreq_o, 1'b1);
         checkBit("to_wait_bus_err", busIf.bus_err_o, 1'b0);
         tick();
      end
      checkBit("to_abort_bus_err", busIf.bus_err_o, 1'b1);
      checkBit("to_abort_stallreq", busIf.stallreq_o, 1'b0);
      checkOutput("to_abort_cpu_data", busIf.cpu_data_o, 32'h0);
      checkBit("to_abort_cyc", busIf.wb_cyc_o, 1'b1);
      tick();
      idleInputs();
      checkBit("to_after_cyc", busIf.wb_cyc_o, 1'b0);
      checkBit("to_after_bus_err", busIf.bus_err_o, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
